bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_pkg.sv | 13 +
 rtl/bus_rr_picker.sv | 36 +++
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - State encoding and parameter defaults for the bus arbiter
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        GRANT      = 2'b01,
        TURNAROUND = 2'b10
    } state_t;

    localparam int NUM_MASTERS_DEFAULT = 4;
    localparam int MAX_HOLD_DEFAULT    = 16;

endpackage

// File: rtl/bus_rr_picker.sv
// rtl/bus_rr_picker.sv - Combinational round-robin search starting at RrPtr
module bus_rr_picker
    import bus_arbiter_pkg::*;
#(
    parameter int NumMasters = NUM_MASTERS_DEFAULT,
    parameter int IW         = (NumMasters > 1) ? $clog2(NumMasters) : 1
) (
    input  logic [NumMasters-1:0] Breq,
    input  logic [IW-1:0]         RrPtr,
    output logic                  Valid,
    output logic [IW-1:0]         WinnerIdx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        Valid     = 1'b0;
        WinnerIdx = '0;
        sum       = '0;
        cand      = '0;
        for (int i = NumMasters - 1; i >= 0; i--) begin
            sum = {1'b0, RrPtr} + (IW + 1)'(i);
            if (sum >= (IW + 1)'(NumMasters)) begin
                sum = sum - (IW + 1)'(NumMasters);
            end
            cand = sum[IW-1:0];
            if (Breq[cand]) begin
                Valid     = 1'b1;
                WinnerIdx = cand;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - Round-robin bus arbiter with bounded hold and a turnaround cycle
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int NumMasters = NUM_MASTERS_DEFAULT,
    parameter int MaxHold    = MAX_HOLD_DEFAULT
) (
    input  logic                  clk,
    input  logic                  bReset,
    input  logic [NumMasters-1:0] Breq,
    output logic [NumMasters-1:0] Bgnt,
    output logic                  BusBusy,
    output logic [1:0]            Owner,
    output logic                  Timeout
);

    localparam int IW = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int HW = (MaxHold > 1) ? $clog2(MaxHold) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MaxHold - 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(NumMasters - 1);

    state_t                state_q, state_d;
    logic [NumMasters-1:0] bgnt_q, bgnt_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]         winner_idx;
    logic [HW-1:0]         hold_q, hold_d;
    logic                  timeout_q, timeout_d;
    logic                  pick_valid;

    bus_rr_picker #(
        .NumMasters(NumMasters),
        .IW        (IW)
    ) u_picker (
        .Breq     (Breq),
        .RrPtr    (rr_ptr_q),
        .Valid    (pick_valid),
        .WinnerIdx(winner_idx)
    );

    always_ff @(posedge clk) begin
        if (bReset) begin
            state_q   <= IDLE;
            bgnt_q    <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bgnt_q    <= bgnt_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    // Leaving GRANT at HOLD_LAST means the counter never needs to wrap.
    always_comb begin
        state_d   = state_q;
        bgnt_d    = bgnt_q;
        owner_d   = owner_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d  = GRANT;
                    bgnt_d   = NumMasters'(1) << winner_idx;
                    owner_d  = winner_idx;
                    rr_ptr_d = (winner_idx == LAST_IDX) ? '0 : winner_idx + 1'b1;
                    hold_d   = '0;
                end
            end
            GRANT: begin
                if (!Breq[owner_q]) begin
                    state_d = TURNAROUND;
                    bgnt_d  = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = TURNAROUND;
                    bgnt_d    = '0;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            TURNAROUND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                bgnt_d  = '0;
            end
        endcase
    end

    assign Bgnt    = bgnt_q;
    assign BusBusy = |bgnt_q;
    assign Owner   = 2'(owner_q);
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - Randomized and directed bench for bus_arbiter against a timeline model
module tb_bus_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    logic         clk = 1'b0;
    logic         bReset;
    logic [N-1:0] Breq;
    logic [N-1:0] Bgnt;
    logic         BusBusy;
    logic [1:0]   Owner;
    logic         Timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: current grantee (-1 none), last grantee, next search start,
    // cycles the grant has been visible, edges still to wait before arbitrating.
    int   m_owner = -1;
    int   m_last  = 0;
    int   m_ptr   = 0;
    int   m_held  = 0;
    int   m_cool  = 0;
    logic m_timeout = 1'b0;

    bus_arbiter #(.NumMasters(N), .MaxHold(MAX_HOLD)) dut (
        .clk    (clk),
        .bReset (bReset),
        .Breq   (Breq),
        .Bgnt   (Bgnt),
        .BusBusy(BusBusy),
        .Owner  (Owner),
        .Timeout(Timeout)
    );

    always #5 clk = ~clk;

    function automatic bit req_bit(input logic [N-1:0] req, input int idx);
        return ((int'(req) >> idx) & 1) == 1;
    endfunction

    task automatic model_edge(input logic [N-1:0] req, input logic rst);
        m_timeout = 1'b0;
        if (rst) begin
            m_owner = -1; m_last = 0; m_ptr = 0; m_held = 0; m_cool = 0;
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (m_owner >= 0) begin
            if (!req_bit(req, m_owner) || m_held == MAX_HOLD) begin
                m_timeout = req_bit(req, m_owner);
                m_owner   = -1;
                m_cool    = 1;
            end else begin
                m_held++;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_owner < 0 && req_bit(req, c)) begin
                    m_owner = c; m_last = c; m_ptr = (c + 1) % N; m_held = 1;
                end
            end
        end
    endtask

    function automatic logic [N+3:0] model_out();
        logic [N-1:0] g;
        g = '0;
        if (m_owner >= 0) g = N'(1) << m_owner;
        return {g, m_owner >= 0, 2'(m_last), m_timeout};
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge(Breq, bReset);
        #1;
    endtask

    task automatic test_reset();
        bReset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Breq = N'($urandom);
            step();
            tests_run++;
            if ({Bgnt, BusBusy, Owner, Timeout} !== '0) begin
                tests_failed++;
                $display("FAIL reset_state: got %b required 0", {Bgnt, BusBusy, Owner, Timeout});
            end
        end
        Breq = 4'b0001;
        step();
        bReset = 1'b0;
        step();
        tests_run++;
        if (Bgnt !== 4'b0001 || Owner !== 2'd0) begin
            tests_failed++;
            $display("FAIL first_arb_after_reset: Bgnt=%b Owner=%0d required 0001/0", Bgnt, Owner);
        end
        Breq = '0;
        step();
        step();
    endtask

    task automatic test_single_request();
        Breq = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (Bgnt !== 4'b0100 || !BusBusy || Owner !== 2'd2) begin
                tests_failed++;
                $display("FAIL single_hold[%0d]: Bgnt=%b Busy=%b Owner=%0d required 0100/1/2", i, Bgnt, BusBusy, Owner);
            end
        end
        Breq = '0;
        step();
        tests_run++;
        if (Bgnt !== '0 || Timeout !== 1'b0 || Owner !== 2'd2) begin
            tests_failed++;
            $display("FAIL single_turnaround: Bgnt=%b Timeout=%b Owner=%0d required 0000/0/2", Bgnt, Timeout, Owner);
        end
        step();
    endtask

    task automatic test_wrap_around();
        Breq = 4'b0011;
        step();
        tests_run++;
        if (Bgnt !== 4'b0001 || Owner !== 2'd0) begin
            tests_failed++;
            $display("FAIL wrap_grant: Bgnt=%b Owner=%0d required 0001/0", Bgnt, Owner);
        end
        Breq = 4'b0010;
        step();
        Breq = 4'b0011;
        step();
        step();
        tests_run++;
        if (Bgnt !== 4'b0010 || Owner !== 2'd1) begin
            tests_failed++;
            $display("FAIL wrap_next_ptr: Bgnt=%b Owner=%0d required 0010/1", Bgnt, Owner);
        end
        Breq = '0;
        step();
        step();
    endtask

    task automatic test_timeout_rotation();
        int seg_owner[$];
        int seg_len[$];
        int gaps[$];
        int zero_run = 0;
        int to_count = 0;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        logic [N-1:0] prev = '0;
        bReset = 1'b1;
        step();
        bReset = 1'b0;
        Breq = 4'b1111;
        for (int c = 0; c < 92; c++) begin
            step();
            tests_run++;
            if ({Bgnt, BusBusy, Owner, Timeout} !== model_out()) begin
                tests_failed++;
                $display("FAIL rotation_cycle[%0d]: got %b required %b", c, {Bgnt, BusBusy, Owner, Timeout}, model_out());
            end
            if (Timeout) to_count++;
            if (Bgnt != '0) begin
                if (prev == '0) begin
                    if (seg_owner.size() > 0) gaps.push_back(zero_run);
                    seg_owner.push_back(onehot_idx(Bgnt));
                    seg_len.push_back(0);
                end
                seg_len[seg_len.size() - 1]++;
                zero_run = 0;
            end else begin
                zero_run++;
            end
            prev = Bgnt;
        end
        tests_run++;
        if (seg_owner.size() < 5 || gaps.size() < 4) begin
            tests_failed++;
            $display("FAIL rotation_segments: got %0d grants required at least 5", seg_owner.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests_run++;
                if (seg_owner[i] != exp_order[i] || seg_len[i] != MAX_HOLD) begin
                    tests_failed++;
                    $display("FAIL rotation_grant[%0d]: owner=%0d len=%0d required %0d/%0d", i, seg_owner[i], seg_len[i], exp_order[i], MAX_HOLD);
                end
            end
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (gaps[i] != 2) begin
                    tests_failed++;
                    $display("FAIL rotation_gap[%0d]: got %0d required 2", i, gaps[i]);
                end
            end
        end
        tests_run++;
        if (to_count != 5) begin
            tests_failed++;
            $display("FAIL rotation_timeouts: got %0d required 5", to_count);
        end
        Breq = '0;
        step();
        step();
        step();
    endtask

    task automatic test_nonowner_pulse();
        logic [N+10:0] seq [13];
        bReset = 1'b1;
        step();
        bReset = 1'b0;
        for (int i = 0; i < 13; i++) begin
            Breq = (i < 3) ? 4'b0001 : (i == 3) ? 4'b0011 : (i < 7) ? 4'b0001 : 4'b0000;
            step();
            tests_run++;
            if (Bgnt[1] !== 1'b0 || {Bgnt, BusBusy, Owner, Timeout} !== model_out()) begin
                tests_failed++;
                $display("FAIL pulse_ignored[%0d]: got %b required %b", i, {Bgnt, BusBusy, Owner, Timeout}, model_out());
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        bReset = 1'b1;
        step();
        bReset = 1'b0;
        Breq = 4'b1000;
        step();
        for (int i = 0; i < 7; i++) step();
        tests_run++;
        if (Bgnt !== 4'b1000) begin
            tests_failed++;
            $display("FAIL midreset_pre: Bgnt=%b required 1000", Bgnt);
        end
        bReset = 1'b1;
        step();
        tests_run++;
        if (Bgnt !== '0 || Owner !== 2'd0 || Timeout !== 1'b0 || BusBusy !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_drop: Bgnt=%b Owner=%0d Timeout=%b required 0000/0/0", Bgnt, Owner, Timeout);
        end
        bReset = 1'b0;
        step();
        tests_run++;
        if (Bgnt !== 4'b1000 || Owner !== 2'd3) begin
            tests_failed++;
            $display("FAIL midreset_rearb: Bgnt=%b Owner=%0d required 1000/3", Bgnt, Owner);
        end
        Breq = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (Timeout !== 1'b0) begin
                tests_failed++;
                $display("FAIL midreset_timeout[%0d]: got %b required 0", i, Timeout);
            end
        end
    endtask

    task automatic test_drop_at_limit();
        bReset = 1'b1;
        step();
        bReset = 1'b0;
        Breq = 4'b0010;
        step();
        for (int i = 0; i < MAX_HOLD - 1; i++) step();
        tests_run++;
        if (Bgnt !== 4'b0010) begin
            tests_failed++;
            $display("FAIL limit_hold: Bgnt=%b required 0010", Bgnt);
        end
        Breq = '0;
        step();
        tests_run++;
        if (Bgnt !== '0 || Timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL limit_release: Bgnt=%b Timeout=%b required 0000/0", Bgnt, Timeout);
        end
        step();
        tests_run++;
        if (Timeout !== 1'b0) begin
            tests_failed++;
            $display("FAIL limit_no_pulse: Timeout=%b required 0", Timeout);
        end
    endtask

    task automatic test_random();
        int last_gnt = -1;
        int zeros = 0;
        bReset = 1'b1;
        step();
        bReset = 1'b0;
        Breq = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(7) == 0) Breq[b] = ~Breq[b];
            bReset = ($urandom_range(199) == 0);
            step();
            tests_run++;
            if ({Bgnt, BusBusy, Owner, Timeout} !== model_out() || !$onehot0(Bgnt)) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %b required %b", c, {Bgnt, BusBusy, Owner, Timeout}, model_out());
            end
            if (bReset) begin
                last_gnt = -1;
                zeros = 2;
            end else if (Bgnt != '0) begin
                if (last_gnt >= 0 && onehot_idx(Bgnt) != last_gnt && zeros < 2) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL random_gap[%0d]: got %0d zero cycles required 2", c, zeros);
                end
                last_gnt = onehot_idx(Bgnt);
                zeros = 0;
            end else begin
                zeros++;
            end
        end
        bReset = 1'b0;
    endtask

    initial begin
        bReset = 1'b1;
        Breq   = '0;
        test_reset();
        test_single_request();
        test_wrap_around();
        test_timeout_rotation();
        test_nonowner_pulse();
        test_reset_mid_grant();
        test_drop_at_limit();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
